// File: rtl/reg_cmd_ctrl.sv
// Command-to-register-bank controller: accepts one read/write command, drives the
// bank for a single EXEC cycle, then holds the response until it is consumed.
module reg_cmd_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int CMD_AW = 8
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic                                   cmd_write,
    input  logic [CMD_AW-1:0]                      cmd_addr,
    input  logic [WIDTH-1:0]                       cmd_wdata,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [WIDTH-1:0]                       rsp_rdata,
    output logic                                   rsp_err,
    output logic                                   rsp_write,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rb_addr,
    output logic                                   rb_write_en,
    output logic [WIDTH-1:0]                       rb_data_in,
    input  logic [WIDTH-1:0]                       rb_data_out,
    output logic [15:0]                            wr_count,
    output logic [7:0]                             err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CMD_AW:0] DEPTH_LIMIT = (CMD_AW + 1)'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic              lat_write;
    logic [CMD_AW-1:0] lat_addr;
    logic [WIDTH-1:0]  lat_wdata;
    logic              addr_err;

    // The full command address is compared, so aliasing high bits never reach the bank.
    assign addr_err    = {1'b0, lat_addr} >= DEPTH_LIMIT;
    assign cmd_ready   = (state == IDLE);
    assign rsp_valid   = (state == RESP);
    assign rb_write_en = (state == EXEC) && lat_write && !addr_err;
    assign rb_addr     = lat_addr[AW-1:0];
    assign rb_data_in  = lat_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_write <= 1'b0;
            err_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= EXEC;
                        lat_write <= cmd_write;
                        lat_addr  <= cmd_addr;
                        lat_wdata <= cmd_wdata;
                    end
                end
                EXEC: begin
                    state     <= RESP;
                    rsp_err   <= addr_err;
                    rsp_write <= lat_write;
                    rsp_rdata <= (!lat_write && !addr_err) ? rb_data_out : '0;
                    if (addr_err && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count <= 16'd0;
        end else if (rb_write_en) begin
            wr_count <= wr_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Scoreboard bench for reg_cmd_ctrl with a behavioural 4x8 register bank attached.
module tb_reg_cmd_ctrl;

    typedef struct {
        logic       w;
        logic       e;
        logic [7:0] d;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_write;
    logic [1:0] rb_addr;
    logic       rb_write_en;
    logic [7:0] rb_data_in;
    logic [7:0] rb_data_out;
    logic [15:0] wr_count;
    logic [7:0]  err_count;

    logic [7:0] bank    [4] = '{default: 8'h00};
    logic [7:0] ref_mem [4] = '{default: 8'h00};
    exp_t       exp_q[$];
    int         checks      = 0;
    int         errors      = 0;
    int         pulse_count = 0;
    int         rsp_seen    = 0;
    int         exp_wr      = 0;
    int         exp_err     = 0;

    reg_cmd_ctrl #(.WIDTH(8), .DEPTH(4), .CMD_AW(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_write(rsp_write),
        .rb_addr(rb_addr), .rb_write_en(rb_write_en), .rb_data_in(rb_data_in),
        .rb_data_out(rb_data_out), .wr_count(wr_count), .err_count(err_count)
    );

    always @(posedge clk) begin
        if (rb_write_en) bank[rb_addr] <= rb_data_in;
    end
    assign rb_data_out = bank[rb_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Expected response is decided at the acceptance edge, from the reference memory.
    task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [7:0] d);
        bit   accepted = 0;
        bit   oor;
        exp_t e;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (cmd_ready) accepted = 1;
        end
        if (!accepted) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        oor = (a >= 8'd4);
        e.w = w;
        e.e = oor;
        e.d = (!w && !oor) ? ref_mem[a[1:0]] : 8'h00;
        exp_q.push_back(e);
        if (w && !oor) begin
            ref_mem[a[1:0]] = d;
            exp_wr++;
        end
        if (oor && exp_err != 255) exp_err++;
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) checkOutput("drain_timeout", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    // Response monitor: every completed handshake is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && rb_write_en) pulse_count++;
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("rsp_write", rsp_write, e.w);
                checkOutput("rsp_err",   rsp_err,   e.e);
                checkOutput("rsp_rdata", rsp_rdata, e.d);
                rsp_seen++;
            end
        end
    end

    initial begin
        int         p0;
        int         seen0;
        logic [7:0] saved;

        reset_n   = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b1;
        #2 reset_n = 1'b0;
        #13;
        checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 8'h00);
        checkOutput("rst_rsp_err", rsp_err, 1'b0);
        checkOutput("rst_rsp_write", rsp_write, 1'b0);
        checkOutput("rst_rb_we", rb_write_en, 1'b0);
        checkOutput("rst_rb_addr", rb_addr, 2'd0);
        checkOutput("rst_rb_data_in", rb_data_in, 8'h00);
        checkOutput("rst_wr_count", wr_count, 16'd0);
        checkOutput("rst_err_count", err_count, 8'd0);
        #7 reset_n = 1'b1;
        #1 checkOutput("post_rst_ready", cmd_ready, 1'b1);

        // Single write: one-cycle strobe, response on the following edge.
        p0 = pulse_count;
        applyStimulus(1'b1, 8'd1, 8'hAA);
        @(negedge clk);
        checkOutput("exec_we", rb_write_en, 1'b1);
        checkOutput("exec_addr", rb_addr, 2'd1);
        checkOutput("exec_data", rb_data_in, 8'hAA);
        checkOutput("exec_rsp_valid", rsp_valid, 1'b0);
        @(negedge clk);
        checkOutput("resp_valid", rsp_valid, 1'b1);
        checkOutput("resp_we_low", rb_write_en, 1'b0);
        waitDrain();
        checkOutput("we_pulse_len", pulse_count - p0, 32'd1);
        checkOutput("wr_count_1", wr_count, exp_wr);

        applyStimulus(1'b1, 8'd2, 8'h55);
        applyStimulus(1'b1, 8'd3, 8'h77);
        applyStimulus(1'b0, 8'd2, 8'h00);
        applyStimulus(1'b0, 8'd3, 8'h00);
        waitDrain();
        checkOutput("wr_count_3", wr_count, exp_wr);

        // Out-of-range write whose low bits alias address 1.
        p0 = pulse_count;
        applyStimulus(1'b1, 8'd5, 8'hF1);
        waitDrain();
        checkOutput("oor_no_pulse", pulse_count - p0, 32'd0);
        checkOutput("oor_err_count", err_count, exp_err);
        for (int i = 0; i < 4; i++) checkOutput("bank_intact", bank[i], ref_mem[i]);

        // Back-pressure with a second command waiting.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 8'd1, 8'h00);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'd0;
        cmd_wdata = 8'h3C;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", rsp_valid, 1'b1);
            checkOutput("stall_rdata", rsp_rdata, 8'hAA);
            checkOutput("stall_err", rsp_err, 1'b0);
            checkOutput("stall_write", rsp_write, 1'b0);
            checkOutput("stall_ready", cmd_ready, 1'b0);
        end
        seen0 = rsp_seen;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        applyStimulus(1'b1, 8'd0, 8'h3C);
        checkOutput("stall_order", rsp_seen, seen0 + 1);
        waitDrain();
        checkOutput("stall_bank0", bank[0], 8'h3C);
        checkOutput("wr_count_4", wr_count, exp_wr);

        // Reset while a response is pending.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 8'd3, 8'h00);
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_rst_valid", rsp_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrsp_valid", rsp_valid, 1'b0);
        checkOutput("midrsp_wr_count", wr_count, 16'd0);
        checkOutput("midrsp_err_count", err_count, 8'd0);
        checkOutput("midrsp_rdata", rsp_rdata, 8'h00);
        exp_q.delete();
        exp_wr    = 0;
        exp_err   = 0;
        rsp_ready = 1'b1;
        #20 reset_n = 1'b1;
        #1 checkOutput("midrsp_ready", cmd_ready, 1'b1);

        // Reset during EXEC must abort the pending write.
        saved = ref_mem[0];
        applyStimulus(1'b1, 8'd0, 8'h11);
        checkOutput("abort_we_before", rb_write_en, 1'b1);
        reset_n = 1'b0;
        #1 checkOutput("abort_we_after", rb_write_en, 1'b0);
        ref_mem[0] = saved;
        exp_wr     = 0;
        exp_q.delete();
        #10 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_bank0", bank[0], 8'h3C);
        checkOutput("abort_wr_count", wr_count, 16'd0);

        applyStimulus(1'b1, 8'd2, 8'h5A);
        applyStimulus(1'b0, 8'd2, 8'h00);
        waitDrain();
        checkOutput("post_abort_wr_count", wr_count, exp_wr);

        // Enough errors to reach the saturation point of err_count.
        for (int i = 0; i < 258; i++) begin
            applyStimulus(1'b0, 8'($urandom_range(4, 255)), 8'h00);
        end
        waitDrain();
        checkOutput("err_saturate", err_count, exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
